br_predict_unit: RTL and testbench

- Parametrised successor to the execute-stage branch decision logic.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, queried at fetch.
- Resolves all six RV32I conditional compares from raw operands at execute, detects mispredictions and issues a registered redirect to fetch.
- Sits between the fetch PC mux and the execution unit.

---
 rtl/br_predict_unit_pkg.sv | 29 ++
 rtl/br_predict_unit_br_cmp.sv | 29 ++
 rtl/br_predict_unit.sv | 123 ++++++++++++
 tb/tb_br_predict_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/br_predict_unit_pkg.sv
// Shared encodings for the branch predictor: compare funct3 codes and
// 2-bit direction counter states with a saturating step helper.
package br_predict_unit_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken && c != ST) r = ctr_t'(c + 2'd1);
    else if (!taken && c != SNT) r = ctr_t'(c - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/br_predict_unit_br_cmp.sv
// Combinational six-way RV32I branch comparator; is_branch flags a legal
// conditional funct3 so the caller can suppress table writes otherwise.
module br_cmp
  import br_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            is_branch
);

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (funct3)
      BR_EQ:   taken = (rs1 == rs2);
      BR_NE:   taken = (rs1 != rs2);
      BR_LT:   taken = ($signed(rs1) < $signed(rs2));
      BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  taken = (rs1 < rs2);
      BR_GEU:  taken = (rs1 >= rs2);
      default: is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_predict_unit.sv
// Direct-mapped BTB with 2-bit counters plus execute-stage resolve/redirect.
// Define BR_PRED_BYPASS_EN to forward a same-cycle update into the lookup.
module br_predict_unit
  import br_predict_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_valid_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            res_valid_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic            res_is_jump_i,
  input  logic [2:0]      res_funct3_i,
  input  logic [XLEN-1:0] res_rs1_i,
  input  logic [XLEN-1:0] res_rs2_i,
  input  logic [XLEN-1:0] res_target_i,
  input  logic            res_pred_taken_i,
  input  logic [XLEN-1:0] res_pred_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_reg  [ENTRIES];
  logic [TAG_W-1:0] tag_reg    [ENTRIES];
  logic [XLEN-1:0]  target_reg [ENTRIES];
  ctr_t             ctr_reg    [ENTRIES];

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = fetch_pc_i[XLEN-1:IDX_W+2];
  assign r_idx = res_pc_i[IDX_W+1:2];
  assign r_tag = res_pc_i[XLEN-1:IDX_W+2];

  logic cmp_taken, cmp_is_branch;
  br_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3    (res_funct3_i),
    .rs1       (res_rs1_i),
    .rs2       (res_rs2_i),
    .taken     (cmp_taken),
    .is_branch (cmp_is_branch)
  );

  logic            actual_taken, r_hit, upd_en, mispredict;
  logic [XLEN-1:0] upd_target, correct_pc;
  ctr_t            upd_ctr;

  always_comb begin
    actual_taken = res_is_jump_i | (cmp_is_branch & cmp_taken);
    r_hit        = valid_reg[r_idx] && (tag_reg[r_idx] == r_tag);
    // Unknown funct3 on a non-jump never touches the table.
    upd_en       = res_valid_i && (res_is_jump_i || cmp_is_branch) && (r_hit || actual_taken);
    upd_target   = actual_taken ? res_target_i : target_reg[r_idx];
    upd_ctr      = r_hit ? ctr_step(ctr_reg[r_idx], actual_taken) : WT;
    mispredict   = res_valid_i && ((actual_taken != res_pred_taken_i) ||
                                   (actual_taken && (res_target_i != res_pred_target_i)));
    correct_pc   = actual_taken ? res_target_i : res_pc_i + XLEN'(4);
  end

  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;
  logic [XLEN-1:0]  lk_target;
  ctr_t             lk_ctr;
  logic             lk_taken;

  always_comb begin
    lk_valid  = valid_reg[f_idx];
    lk_tag    = tag_reg[f_idx];
    lk_target = target_reg[f_idx];
    lk_ctr    = ctr_reg[f_idx];
`ifdef BR_PRED_BYPASS_EN
    if (upd_en && (r_idx == f_idx)) begin
      lk_valid  = 1'b1;
      lk_tag    = r_tag;
      lk_target = upd_target;
      lk_ctr    = upd_ctr;
    end
`endif
    lk_taken = lk_valid && (lk_tag == f_tag) && lk_ctr[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= CTR_RESET;
      end
    end else if (upd_en) begin
      valid_reg[r_idx]  <= 1'b1;
      tag_reg[r_idx]    <= r_tag;
      target_reg[r_idx] <= upd_target;
      ctr_reg[r_idx]    <= upd_ctr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_o  <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      pred_valid_o  <= fetch_valid_i;
      pred_taken_o  <= lk_taken;
      pred_target_o <= lk_taken ? lk_target : fetch_pc_i + XLEN'(4);
      redirect_o    <= mispredict;
      if (mispredict) redirect_pc_o <= correct_pc;
    end
  end

endmodule

// File: tb/tb_br_predict_unit.sv
// Directed self-checking bench for br_predict_unit (default ENTRIES=16);
// same-cycle collision expectation follows BR_PRED_BYPASS_EN.
module tb_br_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic        res_is_jump = 1'b0;
  logic [2:0]  res_funct3 = '0;
  logic [31:0] res_rs1 = '0, res_rs2 = '0, res_target = '0;
  logic        res_pred_taken = 1'b0;
  logic [31:0] res_pred_target = '0;
  logic        redirect;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  br_predict_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .fetch_valid_i     (fetch_valid),
    .fetch_pc_i        (fetch_pc),
    .pred_valid_o      (pred_valid),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .res_valid_i       (res_valid),
    .res_pc_i          (res_pc),
    .res_is_jump_i     (res_is_jump),
    .res_funct3_i      (res_funct3),
    .res_rs1_i         (res_rs1),
    .res_rs2_i         (res_rs2),
    .res_target_i      (res_target),
    .res_pred_taken_i  (res_pred_taken),
    .res_pred_target_i (res_pred_target),
    .redirect_o        (redirect),
    .redirect_pc_o     (redirect_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic        jump;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        exp_redir;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic apply(input logic fv, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] rpc, input logic jump, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    fetch_valid = fv; fetch_pc = fpc;
    res_valid = rv; res_pc = rpc; res_is_jump = jump; res_funct3 = f3;
    res_rs1 = a; res_rs2 = b; res_target = tgt;
    res_pred_taken = ptk; res_pred_target = ptgt;
    @(posedge clk); #1;
    fetch_valid = 1'b0; res_valid = 1'b0; res_is_jump = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    apply(1'b1, pc, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] tgt);
    apply(1'b0, 32'h0, 1'b1, pc, 1'b0, f3, a, b, tgt, 1'b0, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{32'h1004, 1'b0, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h80};
    vecs[1]  = '{32'h1008, 1'b0, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h500, 1'b0, 32'h0,   1'b0, 32'h80};
    vecs[2]  = '{32'h100C, 1'b0, 3'b111, 32'h0,        32'h0, 32'h600, 1'b1, 32'h600, 1'b0, 32'h80};
    vecs[3]  = '{32'h1010, 1'b0, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h700, 1'b0, 32'h0,   1'b1, 32'h700};
    vecs[4]  = '{32'h1014, 1'b0, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h720, 1'b1, 32'h720, 1'b1, 32'h1018};
    vecs[5]  = '{32'h1018, 1'b0, 3'b001, 32'h3,        32'h3, 32'h740, 1'b0, 32'h0,   1'b0, 32'h1018};
    vecs[6]  = '{32'h101C, 1'b0, 3'b001, 32'h3,        32'h4, 32'h800, 1'b1, 32'h804, 1'b1, 32'h800};
    vecs[7]  = '{32'h1020, 1'b0, 3'b101, 32'h1, 32'hFFFFFFFF, 32'h900, 1'b0, 32'h0,   1'b1, 32'h900};
    vecs[8]  = '{32'h1024, 1'b0, 3'b111, 32'h1, 32'hFFFFFFFF, 32'h940, 1'b0, 32'h0,   1'b0, 32'h900};
    vecs[9]  = '{32'h1028, 1'b1, 3'b010, 32'h1,        32'h2, 32'hA00, 1'b0, 32'h0,   1'b1, 32'hA00};
    vecs[10] = '{32'h102C, 1'b0, 3'b010, 32'h5,        32'h5, 32'hA40, 1'b0, 32'h0,   1'b0, 32'hA00};
    vecs[11] = '{32'h1030, 1'b0, 3'b011, 32'h5,        32'h5, 32'hB00, 1'b1, 32'hB00, 1'b1, 32'h1034};
    vecs[12] = '{32'hFFFFFFFC, 1'b0, 3'b000, 32'h1,    32'h2, 32'hC00, 1'b1, 32'hC00, 1'b1, 32'h0};
    vecs[13] = '{32'h1034, 1'b0, 3'b101, 32'hFFFFFFFF, 32'h1, 32'hD00, 1'b0, 32'h0,   1'b0, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst pred_valid", {31'h0, pred_valid}, 32'h0);
    check("rst pred_taken", {31'h0, pred_taken}, 32'h0);
    check("rst pred_target", pred_target, 32'h0);
    check("rst redirect", {31'h0, redirect}, 32'h0);
    check("rst redirect_pc", redirect_pc, 32'h0);
    rst = 1'b0;

    // Cold lookup misses
    lookup(32'h100);
    check("cold pred_valid", {31'h0, pred_valid}, 32'h1);
    check("cold pred_taken", {31'h0, pred_taken}, 32'h0);
    check("cold pred_target", pred_target, 32'h104);
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("idle pred_valid", {31'h0, pred_valid}, 32'h0);

    // BEQ mispredict allocates
    resolve(32'h100, 3'b000, 32'h5, 32'h5, 32'h80);
    check("beq redirect", {31'h0, redirect}, 32'h1);
    check("beq redirect_pc", redirect_pc, 32'h80);
    apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("beq pulse end", {31'h0, redirect}, 32'h0);
    check("beq pc hold", redirect_pc, 32'h80);
    lookup(32'h100);
    check("alloc pred_taken", {31'h0, pred_taken}, 32'h1);
    check("alloc pred_target", pred_target, 32'h80);

    // Compare vectors, back-to-back
    for (int i = 0; i < 14; i++) begin
      apply(1'b0, 32'h0, 1'b1, vecs[i].pc, vecs[i].jump, vecs[i].f3, vecs[i].rs1,
            vecs[i].rs2, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
      check($sformatf("vec%0d redirect", i), {31'h0, redirect}, {31'h0, vecs[i].exp_redir});
      check($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].exp_pc);
    end

    // Table contents left by the vectors
    lookup(32'h1028);
    check("jal alloc taken", {31'h0, pred_taken}, 32'h1);
    check("jal alloc target", pred_target, 32'hA00);
    lookup(32'h102C);
    check("f3 010 no write", {31'h0, pred_taken}, 32'h0);
    lookup(32'h1030);
    check("f3 011 no write", {31'h0, pred_taken}, 32'h0);
    lookup(32'h1008);
    check("nt miss no write", {31'h0, pred_taken}, 32'h0);
    lookup(32'h1004);
    check("blt alloc target", pred_target, 32'h500);

    // Saturation at 00 then climb back to 10
    for (int i = 0; i < 4; i++) resolve(32'h100, 3'b000, 32'h1, 32'h2, 32'h80);
    lookup(32'h100);
    check("sat nt pred_taken", {31'h0, pred_taken}, 32'h0);
    check("sat nt pred_target", pred_target, 32'h104);
    resolve(32'h100, 3'b000, 32'h5, 32'h5, 32'h80);
    lookup(32'h100);
    check("ctr 01 pred_taken", {31'h0, pred_taken}, 32'h0);
    resolve(32'h100, 3'b000, 32'h5, 32'h5, 32'h80);
    lookup(32'h100);
    check("ctr 10 pred_taken", {31'h0, pred_taken}, 32'h1);
    check("ctr 10 pred_target", pred_target, 32'h80);

    // Aliasing eviction
    resolve(32'h140, 3'b000, 32'h5, 32'h5, 32'h180);
    lookup(32'h100);
    check("alias evicted", {31'h0, pred_taken}, 32'h0);
    lookup(32'h140);
    check("alias new taken", {31'h0, pred_taken}, 32'h1);
    check("alias new target", pred_target, 32'h180);

    // Same-cycle lookup and allocate
    apply(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 3'b000, 32'h0, 32'h0, 32'h240, 1'b0, 32'h0);
`ifdef BR_PRED_BYPASS_EN
    check("collide pred_taken", {31'h0, pred_taken}, 32'h1);
    check("collide pred_target", pred_target, 32'h240);
`else
    check("collide pred_taken", {31'h0, pred_taken}, 32'h0);
    check("collide pred_target", pred_target, 32'h204);
`endif
    check("collide redirect", {31'h0, redirect}, 32'h1);
    lookup(32'h200);
    check("post collide taken", {31'h0, pred_taken}, 32'h1);

    // Reset arriving before the mispredict is registered
    fetch_valid = 1'b1; fetch_pc = 32'h200;
    res_valid = 1'b1; res_pc = 32'h300; res_is_jump = 1'b1; res_target = 32'h340;
    res_pred_taken = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rst mid redirect", {31'h0, redirect}, 32'h0);
    res_valid = 1'b0; res_is_jump = 1'b0; fetch_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("post rst redirect %0d", i), {31'h0, redirect}, 32'h0);
    end
    check("post rst pred_valid", {31'h0, pred_valid}, 32'h0);
    lookup(32'h200);
    check("post rst table clear", {31'h0, pred_taken}, 32'h0);
    check("post rst target", pred_target, 32'h204);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
